// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and the starvation FSM encoding for the register-file write-port arbiter.
package rf_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NREG       = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of WB, MDU, decode and register-file signals around the write-port arbiter.
interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;

  // mdu_valid/mdu_ready: a result transfers on a posedge where both are high;
  // while mdu_valid && !mdu_ready the MDU holds mdu_rd/mdu_wd stable.
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_wd;
  logic                  mdu_valid;
  logic [REG_ADDR_W-1:0] mdu_rd;
  logic [XLEN-1:0]       mdu_wd;
  logic                  mdu_ready;
  logic                  issue_mdu;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_stall;
  logic                  wb_hold;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_wa;
  logic [XLEN-1:0]       rf_wd;
  logic [NREG-1:0]       pending;
  state_t                state;

  modport master (
    output wb_we, wb_rd, wb_wd, mdu_valid, mdu_rd, mdu_wd,
           issue_mdu, id_rs1, id_rs2, id_rd,
    input  mdu_ready, id_stall, wb_hold, rf_we, rf_wa, rf_wd, pending, state
  );

  modport slave (
    input  wb_we, wb_rd, wb_wd, mdu_valid, mdu_rd, mdu_wd,
           issue_mdu, id_rs1, id_rs2, id_rd,
    output mdu_ready, id_stall, wb_hold, rf_we, rf_wa, rf_wd, pending, state
  );

endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Synchronous FIFO buffering MDU results ({rd, data}) until the write port is free.
module rf_wb_arbiter_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between WB and buffered MDU results,
// with a starvation guard and a pending-write scoreboard that stalls decode.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH  = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);

  localparam int ENTRY_W  = REG_ADDR_W + XLEN;
  localparam int CNT_W    = $clog2(BUF_DEPTH) + 1;
  localparam int STARVE_W = $clog2(MAX_STARVE + 1);
  localparam logic [STARVE_W-1:0] STARVE_ONE   = STARVE_W'(1);
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(MAX_STARVE - 1);
  localparam logic [CNT_W-1:0]    ONE_LEFT     = CNT_W'(1);

  state_t                state;
  state_t                state_next;
  logic [STARVE_W-1:0]   starve;
  logic [STARVE_W-1:0]   starve_next;
  logic [ENTRY_W-1:0]    head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_wd;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  push;
  logic                  pop;
  logic                  hold;
  logic                  wb_win;
  logic                  denied;
  logic                  drains_empty;
  logic                  stall;
  logic [NREG-1:0]       pending;
  logic [NREG-1:0]       pending_next;
  logic [NREG-1:0]       set_mask;
  logic [NREG-1:0]       clr_mask;

  assign {head_rd, head_wd} = head;

  // Results for x0 complete the handshake but are never buffered.
  assign push   = bus.mdu_valid & ~fifo_full & (bus.mdu_rd != '0);
  assign hold   = (state == FORCE);
  assign wb_win = bus.wb_we & (bus.wb_rd != '0) & ~hold;
  assign pop    = ~fifo_empty & ~wb_win;
  assign denied = ~fifo_empty & wb_win;
  assign drains_empty = pop & ~push & (fifo_count == ONE_LEFT);

  rf_wb_arbiter_wb_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({bus.mdu_rd, bus.mdu_wd}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_wa = '0;
    bus.rf_wd = '0;
    if (wb_win) begin
      bus.rf_we = 1'b1;
      bus.rf_wa = bus.wb_rd;
      bus.rf_wd = bus.wb_wd;
    end else if (pop) begin
      bus.rf_we = 1'b1;
      bus.rf_wa = head_rd;
      bus.rf_wd = head_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      starve  <= '0;
      pending <= '0;
    end else begin
      state   <= state_next;
      starve  <= starve_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    state_next  = state;
    starve_next = starve;
    case (state)
      IDLE: begin
        starve_next = '0;
        if (push) state_next = WAIT;
      end
      WAIT: begin
        if (pop) begin
          starve_next = '0;
          if (drains_empty) state_next = IDLE;
        end else if (denied) begin
          if (starve >= STARVE_LIMIT) state_next = FORCE;
          else                        starve_next = starve + STARVE_ONE;
        end
      end
      FORCE: begin
        starve_next = '0;
        state_next  = drains_empty ? IDLE : WAIT;
      end
      default: begin
        state_next  = IDLE;
        starve_next = '0;
      end
    endcase
  end

  always_comb begin
    stall = 1'b0;
    if (bus.id_rs1 != '0 && pending[bus.id_rs1]) stall = 1'b1;
    if (bus.id_rs2 != '0 && pending[bus.id_rs2]) stall = 1'b1;
    if (bus.issue_mdu && bus.id_rd != '0 && pending[bus.id_rd]) stall = 1'b1;
  end

  // The bit stays set through its write cycle; a same-index set beats the clear.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.issue_mdu && !stall && bus.id_rd != '0) set_mask[bus.id_rd] = 1'b1;
    if (pop) clr_mask[head_rd] = 1'b1;
    pending_next    = (pending & ~clr_mask) | set_mask;
    pending_next[0] = 1'b0;
  end

  assign bus.mdu_ready = ~fifo_full;
  assign bus.id_stall  = stall;
  assign bus.wb_hold   = hold;
  assign bus.pending   = pending;
  assign bus.state     = state;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scenarios for the write-port arbiter with a write-order scoreboard.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_wb_arbiter_if bus();

  rf_wb_arbiter #(.BUF_DEPTH(2), .MAX_STARVE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] exp_item;
  logic        mon_en = 1'b0;
  logic        wb_expect_win = 1'b0;
  logic [31:0] held_wd;

  // Scoreboard: every write that WB is not expected to own must be the oldest queued MDU result.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wb_expect_win) begin
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_wa !== bus.wb_rd || bus.rf_wd !== bus.wb_wd) begin
          errors++;
          $display("FAIL mon_wb_write: got we=%b wa=%0d wd=%h expected we=1 wa=%0d wd=%h",
                   bus.rf_we, bus.rf_wa, bus.rf_wd, bus.wb_rd, bus.wb_wd);
        end
      end else if (bus.rf_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_unexpected_write: got wa=%0d wd=%h expected no write", bus.rf_wa, bus.rf_wd);
        end else begin
          exp_item = exp_q.pop_front();
          if ({bus.rf_wa, bus.rf_wd} !== exp_item) begin
            errors++;
            $display("FAIL mon_mdu_write: got wa=%0d wd=%h expected wa=%0d wd=%h",
                     bus.rf_wa, bus.rf_wd, exp_item[36:32], exp_item[31:0]);
          end
        end
      end else begin
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_wa !== 5'd0 || bus.rf_wd !== 32'd0) begin
          errors++;
          $display("FAIL mon_idle_port: got we=%b wa=%0d wd=%h expected 0/0/0", bus.rf_we, bus.rf_wa, bus.rf_wd);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_wd = '0;
    bus.mdu_valid = 1'b0; bus.mdu_rd = '0; bus.mdu_wd = '0;
    bus.issue_mdu = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    wb_expect_win = 1'b0;
  endtask

  task automatic wb_busy(input logic [4:0] rd, input logic win);
    bus.wb_we = 1'b1; bus.wb_rd = rd; bus.wb_wd = $urandom;
    wb_expect_win = win;
  endtask

  task automatic wb_idle();
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_wd = '0;
    wb_expect_win = 1'b0;
  endtask

  // Drives a result the bench knows will be accepted this cycle.
  task automatic mdu_push(input logic [4:0] rd, input logic [31:0] wd);
    bus.mdu_valid = 1'b1; bus.mdu_rd = rd; bus.mdu_wd = wd;
    if (rd != 5'd0) exp_q.push_back({rd, wd});
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.issue_mdu = 1'b1; bus.id_rd = rd;
  endtask

  task automatic no_issue();
    bus.issue_mdu = 1'b0; bus.id_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd5; bus.mdu_wd = 32'h1111_1111;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h expected 0", bus.pending); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b expected 0", bus.rf_we); end
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL reset_mdu_ready: got %b expected 1", bus.mdu_ready); end
    checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL reset_id_stall: got %b expected 0", bus.id_stall); end
    checks++; if (bus.wb_hold !== 1'b0) begin errors++; $display("FAIL reset_wb_hold: got %b expected 0", bus.wb_hold); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.state, IDLE); end
    bus.mdu_valid = 1'b0;
    rst = 1'b1;
    mon_en = 1'b1;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.rf_we !== 1'b0 || bus.state !== IDLE) begin errors++; $display("FAIL post_reset_quiet: got we=%b state=%0d expected 0/%0d", bus.rf_we, bus.state, IDLE); end
      next_cycle();
    end
  endtask

  task automatic test_idle_drain();
    issue(5'd5); bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2;
    @(negedge clk);
    checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL drain_issue_stall: got %b expected 0", bus.id_stall); end
    next_cycle();
    no_issue(); bus.id_rs1 = '0; bus.id_rs2 = '0;
    mdu_push(5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++; if (bus.pending !== 32'h0000_0020) begin errors++; $display("FAIL drain_pending_set: got %h expected 00000020", bus.pending); end
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL drain_ready: got %b expected 1", bus.mdu_ready); end
    next_cycle();
    bus.mdu_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd5 || bus.rf_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL drain_write: got we=%b wa=%0d wd=%h expected 1/5/deadbeef", bus.rf_we, bus.rf_wa, bus.rf_wd); end
    checks++; if (bus.pending !== 32'h0000_0020) begin errors++; $display("FAIL drain_pending_hold: got %h expected 00000020", bus.pending); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.pending !== 32'd0 || bus.state !== IDLE) begin errors++; $display("FAIL drain_cleared: got pending=%h state=%0d expected 0/%0d", bus.pending, bus.state, IDLE); end
    next_cycle();
  endtask

  task automatic test_raw_stall();
    issue(5'd7);
    next_cycle();
    no_issue(); bus.id_rs2 = 5'd7;
    wb_busy(5'd9, 1'b1);
    mdu_push(5'd7, $urandom);
    @(negedge clk);
    checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_rs2: got %b expected 1", bus.id_stall); end
    next_cycle();
    bus.mdu_valid = 1'b0; bus.id_rs2 = '0; issue(5'd7);
    wb_busy(5'd9, 1'b1);
    @(negedge clk);
    checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("FAIL waw_stall_rd: got %b expected 1", bus.id_stall); end
    next_cycle();
    no_issue(); bus.id_rs2 = 5'd7;
    wb_idle();
    @(negedge clk);
    checks++; if (bus.id_stall !== 1'b1 || bus.rf_wa !== 5'd7) begin errors++; $display("FAIL raw_stall_write_cycle: got stall=%b wa=%0d expected 1/7", bus.id_stall, bus.rf_wa); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL raw_stall_release: got %b expected 0", bus.id_stall); end
    next_cycle();
    bus.id_rs2 = '0; bus.id_rs1 = '0; issue(5'd0);
    mdu_push(5'd0, $urandom);
    @(negedge clk);
    checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL x0_no_stall: got %b expected 0", bus.id_stall); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.pending !== 32'd0 || bus.state !== IDLE) begin errors++; $display("FAIL x0_discard: got pending=%h state=%0d expected 0/%0d", bus.pending, bus.state, IDLE); end
    next_cycle();
  endtask

  task automatic test_starvation();
    issue(5'd3);
    next_cycle();
    no_issue();
    mdu_push(5'd3, 32'hA5A5_0003);
    wb_busy(5'd9, 1'b1);
    next_cycle();
    bus.mdu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_busy(5'd9, 1'b1);
      @(negedge clk);
      checks++; if (bus.wb_hold !== 1'b0) begin errors++; $display("FAIL starve_wb_wins_%0d: got hold=%b expected 0", i, bus.wb_hold); end
      next_cycle();
    end
    wb_busy(5'd9, 1'b0);
    @(negedge clk);
    checks++; if (bus.wb_hold !== 1'b1 || bus.rf_wa !== 5'd3 || bus.state !== FORCE) begin errors++; $display("FAIL starve_force: got hold=%b wa=%0d state=%0d expected 1/3/%0d", bus.wb_hold, bus.rf_wa, bus.state, FORCE); end
    next_cycle();
    wb_busy(5'd9, 1'b1);
    @(negedge clk);
    checks++; if (bus.wb_hold !== 1'b0 || bus.state !== IDLE || bus.pending !== 32'd0) begin errors++; $display("FAIL starve_release: got hold=%b state=%0d pending=%h expected 0/%0d/0", bus.wb_hold, bus.state, bus.pending, IDLE); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_full_fifo();
    for (int i = 0; i < 3; i++) begin
      issue(5'(10 + i));
      next_cycle();
    end
    no_issue();
    wb_busy(5'd9, 1'b1);
    mdu_push(5'd10, $urandom);
    @(negedge clk);
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_first: got %b expected 1", bus.mdu_ready); end
    next_cycle();
    wb_busy(5'd9, 1'b1);
    mdu_push(5'd11, $urandom);
    @(negedge clk);
    checks++; if (bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_second: got %b expected 1", bus.mdu_ready); end
    next_cycle();
    wb_busy(5'd9, 1'b1);
    held_wd = $urandom;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd12; bus.mdu_wd = held_wd;
    @(negedge clk);
    checks++; if (bus.mdu_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready: got %b expected 0", bus.mdu_ready); end
    checks++; if (bus.pending !== 32'h0000_1C00) begin errors++; $display("FAIL full_pending: got %h expected 00001c00", bus.pending); end
    next_cycle();
    wb_idle();
    @(negedge clk);
    checks++; if (bus.mdu_ready !== 1'b0 || bus.rf_wa !== 5'd10) begin errors++; $display("FAIL full_pop_cycle: got ready=%b wa=%0d expected 0/10", bus.mdu_ready, bus.rf_wa); end
    next_cycle();
    exp_q.push_back({5'd12, held_wd});
    @(negedge clk);
    checks++; if (bus.mdu_ready !== 1'b1 || bus.rf_wa !== 5'd11) begin errors++; $display("FAIL full_accept_after_pop: got ready=%b wa=%0d expected 1/11", bus.mdu_ready, bus.rf_wa); end
    next_cycle();
    bus.mdu_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.rf_wa !== 5'd12 || bus.rf_wd !== held_wd) begin errors++; $display("FAIL full_held_result: got wa=%0d wd=%h expected 12/%h", bus.rf_wa, bus.rf_wd, held_wd); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.pending !== 32'd0 || bus.state !== IDLE) begin errors++; $display("FAIL full_end: got pending=%h state=%0d expected 0/%0d", bus.pending, bus.state, IDLE); end
    next_cycle();
  endtask

  task automatic test_collision();
    issue(5'd4);
    next_cycle();
    no_issue();
    mdu_push(5'd4, $urandom);
    next_cycle();
    bus.mdu_valid = 1'b0; issue(5'd4);
    @(negedge clk);
    checks++; if (bus.id_stall !== 1'b1 || bus.rf_wa !== 5'd4) begin errors++; $display("FAIL coll_same_rd_stall: got stall=%b wa=%0d expected 1/4", bus.id_stall, bus.rf_wa); end
    next_cycle();
    no_issue();
    @(negedge clk);
    checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL coll_blocked_no_set: got %h expected 0", bus.pending); end
    next_cycle();
    issue(5'd4);
    next_cycle();
    no_issue();
    mdu_push(5'd4, $urandom);
    next_cycle();
    bus.mdu_valid = 1'b0; issue(5'd6);
    @(negedge clk);
    checks++; if (bus.id_stall !== 1'b0 || bus.rf_wa !== 5'd4) begin errors++; $display("FAIL coll_other_rd: got stall=%b wa=%0d expected 0/4", bus.id_stall, bus.rf_wa); end
    next_cycle();
    no_issue();
    mdu_push(5'd8, $urandom);
    @(negedge clk);
    checks++; if (bus.pending !== 32'h0000_0040) begin errors++; $display("FAIL coll_set_and_clear: got %h expected 00000040", bus.pending); end
    next_cycle();
    bus.mdu_valid = 1'b0; issue(5'd8);
    @(negedge clk);
    checks++; if (bus.id_stall !== 1'b0 || bus.rf_wa !== 5'd8) begin errors++; $display("FAIL coll_unissued_drain: got stall=%b wa=%0d expected 0/8", bus.id_stall, bus.rf_wa); end
    next_cycle();
    no_issue();
    mdu_push(5'd6, $urandom);
    @(negedge clk);
    checks++; if (bus.pending !== 32'h0000_0140) begin errors++; $display("FAIL coll_set_wins: got %h expected 00000140", bus.pending); end
    next_cycle();
    mdu_push(5'd8, $urandom);
    next_cycle();
    bus.mdu_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.pending !== 32'd0 || bus.state !== IDLE) begin errors++; $display("FAIL coll_cleanup: got pending=%h state=%0d expected 0/%0d", bus.pending, bus.state, IDLE); end
    next_cycle();
  endtask

  task automatic test_reset_mid_op();
    issue(5'd13);
    next_cycle();
    no_issue();
    wb_busy(5'd9, 1'b1);
    mdu_push(5'd13, $urandom);
    next_cycle();
    bus.mdu_valid = 1'b0;
    wb_busy(5'd9, 1'b1);
    @(negedge clk);
    checks++; if (bus.pending !== 32'h0000_2000 || bus.state !== WAIT) begin errors++; $display("FAIL midrst_before: got pending=%h state=%0d expected 00002000/%0d", bus.pending, bus.state, WAIT); end
    next_cycle();
    mon_en = 1'b0;
    idle_inputs();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    checks++; if (bus.pending !== 32'd0 || bus.rf_we !== 1'b0 || bus.state !== IDLE || bus.mdu_ready !== 1'b1) begin errors++; $display("FAIL midrst_after: got pending=%h we=%b state=%0d ready=%b expected 0/0/%0d/1", bus.pending, bus.rf_we, bus.state, IDLE, bus.mdu_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL midrst_dropped: got we=%b expected 0", bus.rf_we); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_idle_drain();
    test_raw_stall();
    test_starvation();
    test_full_fifo();
    test_collision();
    test_reset_mid_op();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline writeback (WB) stage and the multi-cycle multiply/divide unit (MDU).
- MDU results are buffered in a small FIFO and drained into idle WB cycles.
- A 32-bit pending-write scoreboard tracks registers awaiting MDU results and generates a decode stall for RAW/WAW hazards.
- Sits between the WB stage, MDU and register file; drives the register-file write enable, address and data.

Parameters:
- BUF_DEPTH, 2, MDU result FIFO entries (power of two, >=2)
- MAX_STARVE, 4, consecutive cycles a non-empty FIFO may be denied the port before WB is held

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, active-low, synchronous
- wb_we  in  1  WB stage write request
- wb_rd  in  5  WB destination register
- wb_wd  in  32  WB write data
- mdu_valid  in  1  MDU result valid
- mdu_rd  in  5  MDU destination register
- mdu_wd  in  32  MDU result data
- mdu_ready  out  1  FIFO can accept a result (not full)
- issue_mdu  in  1  decode issues an MDU op this cycle (qualified by !id_stall)
- id_rs1  in  5  decode source 1
- id_rs2  in  5  decode source 2
- id_rd  in  5  decode destination
- id_stall  out  1  decode must stall (hazard on pending register)
- wb_hold  out  1  WB/pipeline must freeze this cycle (starvation relief)
- rf_we  out  1  register-file write enable
- rf_wa  out  5  register-file write address
- rf_wd  out  32  register-file write data
- pending  out  32  scoreboard bits; bit 0 always 0

Behaviour:
- Reset (rst==0 at posedge): FIFO empty, pending=0, starve counter=0, FSM=IDLE. Outputs therefore read mdu_ready=1, wb_hold=0, id_stall=0, rf_we=0.
- FIFO push: on mdu_valid && mdu_ready. Results with mdu_rd==0 are accepted and discarded (no push).
- Write-port mux is combinational; the register file samples on negedge, so there are no added cycles.
  - wb_we && wb_rd!=0 && !wb_hold: rf_we=1, rf_wa/rf_wd = WB fields.
  - Otherwise, if the FIFO is non-empty: rf_we=1 with the FIFO head; pop at posedge.
  - Otherwise rf_we=0, rf_wa=0, rf_wd=0.
- A WB write to x0 counts as port-idle, so the FIFO may drain that cycle.
- FSM states:
  - IDLE: FIFO empty. Go to WAIT on push.
  - WAIT: FIFO non-empty. Each cycle the head is denied the port, starve++ (saturating). A pop resets starve to 0.
    - To IDLE when the FIFO becomes empty.
    - To FORCE when starve reaches MAX_STARVE-1 and the head is denied again.
  - FORCE: wb_hold=1, so the head is written this cycle. Pop, starve=0, then go to WAIT (still non-empty) or IDLE.
  - wb_hold is asserted only in FORCE, for exactly one cycle per entry.
- Scoreboard:
  - Set pending[id_rd] on issue_mdu && !id_stall && id_rd!=0.
  - Clear pending[rf_wa] when the FIFO head is written.
  - Simultaneous set and clear of the same index: set wins.
- id_stall (combinational) = pending[id_rs1] | pending[id_rs2] | (issue_mdu & pending[id_rd]), with the index-0 terms forced 0.
  - The pending bit stays set through the write cycle, so a dependent instruction decodes the cycle after the RF write.
  - WAW is therefore impossible in the FIFO; it never holds two entries for the same rd.
- Full FIFO: mdu_ready=0; the MDU must hold its result.
  - Same-cycle pop and push when full is NOT allowed: mdu_ready depends only on registered count.
- Simultaneous push and pop when not full: count unchanged, pointers wrap modulo BUF_DEPTH.
- Reset mid-operation: all buffered results and pending bits are dropped. The MDU is reset by the same rst.

Decomposition:
- Shared package: REG_ADDR_W=5, XLEN=32, and FSM state enum {IDLE, WAIT, FORCE}.
- One natural sub-module: wb_fifo (synchronous FIFO, BUF_DEPTH x 37 bits, push/pop/full/empty/count). The arbiter, FSM and scoreboard stay in the top.

Test Plan:
- Reset: hold rst=0 two cycles with mdu_valid=1 -> pending=0, rf_we=0, mdu_ready=1, id_stall=0. Nothing is written after rst=1 until a new push.
- Idle drain: issue_mdu rd=5; MDU pushes rd=5, wd=0xDEADBEEF; wb_we=0 -> next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF, then pending[5]=0.
- RAW stall: pending[7]=1, id_rs2=7 -> id_stall=1 until the cycle after rd=7 is written; id_rs1=0 with pending[0] never stalls.
- Starvation (MAX_STARVE=4): FIFO holds rd=3 while wb_we=1 rd=9 every cycle -> WB wins 4 cycles, 5th cycle wb_hold=1 and rf_wa=3. wb_hold drops the next cycle.
- Full FIFO: 2 pushes with WB busy -> mdu_ready=0. A third mdu_valid is held off and is accepted only after a pop.
- Set/clear collision: the cycle rd=4 drains, issue_mdu id_rd=4 is blocked by id_stall=1. A different rd=6 issued in the same cycle sets pending[6] while pending[4] clears.
